pc_sequencer: RTL and testbench

- Parametrised program-counter and interrupt sequencer for the RISC core; replaces the fixed 9-bit PC register, next-PC mux and single hard-wired ISR address.
- Adds N prioritised, latched interrupt channels with vectored entry, nested preemption by priority, and a hardware return stack shared by calls and interrupts.
- The state machine drives load_pc/pc_sel/call. The instruction fetch path reads pc.

---
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and vectored interrupt sequencer for the RISC core.
// Latched, prioritised interrupt channels with a return stack shared by calls and ISRs.
module pc_sequencer #(
  parameter int ADDR_W      = 9,
  parameter int NUM_IRQ     = 4,
  parameter int STACK_DEPTH = 8,
  parameter int ISR_BASE    = 10,
  parameter int ISR_STRIDE  = 4,
  parameter int RESET_PC    = 0,
  localparam int ID_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  localparam int LVL_W = $clog2(NUM_IRQ + 1),
  localparam int SP_W  = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_pc,
  input  logic [2:0]        pc_sel,
  input  logic              call,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [ADDR_W-1:0] pc,
  output logic              irq_pending,
  output logic [ID_W-1:0]   irq_id,
  output logic              in_isr,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int ENT_W = LVL_W + ADDR_W;

  logic [NUM_IRQ-1:0] pend;
  logic [LVL_W-1:0]   level;
  logic [SP_W-1:0]    sp;
  logic [ENT_W-1:0]   stack_mem [STACK_DEPTH];

  logic [ADDR_W-1:0]  pc_nxt;
  logic [LVL_W-1:0]   level_nxt;
  logic [SP_W-1:0]    sp_nxt;
  logic               push;
  logic [ENT_W-1:0]   push_data;
  logic               push_ok;
  logic               ovf_set;
  logic               unf_set;
  logic [NUM_IRQ-1:0] pend_clr;
  logic [ENT_W-1:0]   top;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [ADDR_W-1:0]  vec_addr;

  // Channels below the running level are eligible; scanning downward leaves the lowest index.
  always_comb begin
    irq_pending = 1'b0;
    irq_id      = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i] && (i < int'(level))) begin
        irq_pending = 1'b1;
        irq_id      = ID_W'(i);
      end
    end
  end

  assign in_isr      = (level != LVL_W'(NUM_IRQ));
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

  assign wr_idx   = IDX_W'(sp);
  assign rd_idx   = IDX_W'(sp - SP_W'(1));
  assign top      = stack_mem[rd_idx];
  assign vec_addr = ADDR_W'(ISR_BASE + int'(irq_id) * ISR_STRIDE);
  assign push_ok  = push && !stack_full;

  always_comb begin
    pc_nxt    = pc;
    level_nxt = level;
    sp_nxt    = sp;
    push      = 1'b0;
    push_data = '0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    pend_clr  = '0;
    if (load_pc) begin
      case (pc_sel)
        3'd1: pc_nxt = ADDR_W'(RESET_PC);
        3'd2, 3'd3: begin
          pc_nxt = (pc_sel == 3'd2) ? branch_target : reg_target;
          if (call) begin
            push      = 1'b1;
            push_data = {level, pc + ADDR_W'(1)};
          end
        end
        3'd4: begin
          if (irq_pending) begin
            push             = 1'b1;
            push_data        = {level, pc};
            pc_nxt           = vec_addr;
            level_nxt        = LVL_W'(irq_id);
            pend_clr[irq_id] = 1'b1;
          end
        end
        3'd5: begin
          if (!stack_empty) begin
            pc_nxt    = top[ADDR_W-1:0];
            level_nxt = top[ENT_W-1:ADDR_W];
            sp_nxt    = sp - SP_W'(1);
          end else begin
            unf_set   = 1'b1;
            pc_nxt    = ADDR_W'(RESET_PC);
            level_nxt = LVL_W'(NUM_IRQ);
          end
        end
        default: pc_nxt = pc + ADDR_W'(1);
      endcase
    end
    // A push onto a full stack is dropped but the jump itself still happens.
    if (push) begin
      if (stack_full) ovf_set = 1'b1;
      else            sp_nxt  = sp + SP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= ADDR_W'(RESET_PC);
      pend      <= '0;
      level     <= LVL_W'(NUM_IRQ);
      sp        <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      pend      <= (pend | irq_req) & ~pend_clr;
      level     <= level_nxt;
      sp        <= sp_nxt;
      stack_ovf <= stack_ovf | ovf_set;
      stack_unf <= stack_unf | unf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) stack_mem[wr_idx] <= push_data;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_pc_sequencer;

  localparam int NUM_IRQ = 4;
  localparam int DEPTH   = 8;
  localparam int PC_MOD  = 512;
  localparam int ISR_BASE = 10;
  localparam int ISR_STRIDE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_pc = 1'b0;
  logic [2:0] pc_sel = 3'd0;
  logic       call = 1'b0;
  logic [8:0] branch_target = '0;
  logic [8:0] reg_target = '0;
  logic [3:0] irq_req = '0;
  logic [8:0] pc;
  logic       irq_pending;
  logic [1:0] irq_id;
  logic       in_isr, stack_full, stack_empty, stack_ovf, stack_unf;

  int checks = 0;
  int failures = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .load_pc(load_pc), .pc_sel(pc_sel), .call(call),
    .branch_target(branch_target), .reg_target(reg_target), .irq_req(irq_req),
    .pc(pc), .irq_pending(irq_pending), .irq_id(irq_id), .in_isr(in_isr),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers and a queue as the return stack.
  typedef struct { int lvl; int ret; } ent_t;
  ent_t m_stack[$];
  int   m_pc, m_level;
  bit [3:0] m_pend;
  bit   m_ovf, m_unf;

  task automatic model_reset();
    m_stack.delete();
    m_pc = 0; m_level = NUM_IRQ; m_pend = '0; m_ovf = 0; m_unf = 0;
  endtask

  function automatic int model_id();
    for (int i = 0; i < NUM_IRQ; i++)
      if (m_pend[i] && i < m_level) return i;
    return -1;
  endfunction

  task automatic model_step(input bit ld, input bit [2:0] sel, input bit cl,
                            input int bt, input int rt, input bit [3:0] rq);
    int id;
    bit [3:0] np;
    bit do_push;
    ent_t e;
    id = model_id();
    np = m_pend | rq;
    do_push = 0;
    e = '{0, 0};
    if (ld) begin
      case (sel)
        3'd1: m_pc = 0;
        3'd2, 3'd3: begin
          if (cl) begin e = '{m_level, (m_pc + 1) % PC_MOD}; do_push = 1; end
          m_pc = (sel == 3'd2) ? bt : rt;
        end
        3'd4: if (id >= 0) begin
          e = '{m_level, m_pc}; do_push = 1;
          m_pc = (ISR_BASE + ISR_STRIDE * id) % PC_MOD;
          m_level = id;
          np[id] = 1'b0;
        end
        3'd5: if (m_stack.size() > 0) begin
          e = m_stack.pop_back();
          m_pc = e.ret; m_level = e.lvl;
        end else begin
          m_unf = 1; m_pc = 0; m_level = NUM_IRQ;
        end
        default: m_pc = (m_pc + 1) % PC_MOD;
      endcase
    end
    if (do_push) begin
      if (m_stack.size() == DEPTH) m_ovf = 1;
      else m_stack.push_back(e);
    end
    m_pend = np;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit ld, input bit [2:0] sel, input bit cl,
                      input int bt, input int rt, input bit [3:0] rq);
    load_pc = ld; pc_sel = sel; call = cl;
    branch_target = 9'(bt); reg_target = 9'(rt); irq_req = rq;
    @(posedge clk);
    model_step(ld, sel, cl, bt, rt, rq);
    #1;
  endtask

  task automatic check_model(input string tag);
    int id;
    id = model_id();
    chk({tag, " pc"}, 32'(pc), 32'(m_pc));
    chk({tag, " irq_pending"}, 32'(irq_pending), 32'(id >= 0));
    chk({tag, " irq_id"}, 32'(irq_id), 32'((id >= 0) ? id : 0));
    chk({tag, " in_isr"}, 32'(in_isr), 32'(m_level != NUM_IRQ));
    chk({tag, " stack_full"}, 32'(stack_full), 32'(m_stack.size() == DEPTH));
    chk({tag, " stack_empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    chk({tag, " stack_ovf"}, 32'(stack_ovf), 32'(m_ovf));
    chk({tag, " stack_unf"}, 32'(stack_unf), 32'(m_unf));
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  typedef struct {
    bit ld; bit [2:0] sel; bit cl; int bt; int rt; bit [3:0] rq;
    int pc; bit pnd; int id; bit isr; bit emp;
  } vec_t;
  vec_t tbl[11];

  int t[9];
  int ret_exp[$];
  int pc_before;

  initial begin
    tbl[0]  = '{1, 3'd2, 0, 'h1FE, 0,    4'b0000, 'h1FE, 0, 0, 0, 1};
    tbl[1]  = '{1, 3'd0, 0, 0,     0,    4'b0000, 'h1FF, 0, 0, 0, 1};
    tbl[2]  = '{1, 3'd0, 0, 0,     0,    4'b0000, 'h000, 0, 0, 0, 1};
    tbl[3]  = '{1, 3'd7, 0, 0,     0,    4'b0000, 'h001, 0, 0, 0, 1};
    tbl[4]  = '{1, 3'd6, 1, 'h77,  0,    4'b0000, 'h002, 0, 0, 0, 1};
    tbl[5]  = '{1, 3'd3, 0, 0,     'h20, 4'b0000, 'h020, 0, 0, 0, 1};
    tbl[6]  = '{0, 3'd4, 0, 0,     0,    4'b0100, 'h020, 1, 2, 0, 1};
    tbl[7]  = '{1, 3'd4, 0, 0,     0,    4'b0000, 18,    0, 0, 1, 0};
    tbl[8]  = '{1, 3'd5, 0, 0,     0,    4'b0000, 'h020, 0, 0, 0, 1};
    tbl[9]  = '{1, 3'd4, 0, 0,     0,    4'b0000, 'h020, 0, 0, 0, 1};
    tbl[10] = '{1, 3'd1, 0, 0,     0,    4'b0000, 'h000, 0, 0, 0, 1};

    // Asynchronous reset, observed before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("reset pc", 32'(pc), 0);
    chk("reset stack_empty", 32'(stack_empty), 1);
    chk("reset in_isr", 32'(in_isr), 0);
    chk("reset irq_pending", 32'(irq_pending), 0);
    chk("reset stack_ovf", 32'(stack_ovf), 0);
    chk("reset stack_unf", 32'(stack_unf), 0);
    #1 reset = 1'b0;
    model_reset();

    foreach (tbl[k]) begin
      step(tbl[k].ld, tbl[k].sel, tbl[k].cl, tbl[k].bt, tbl[k].rt, tbl[k].rq);
      chk($sformatf("vec%0d pc", k), 32'(pc), 32'(tbl[k].pc));
      chk($sformatf("vec%0d irq_pending", k), 32'(irq_pending), 32'(tbl[k].pnd));
      chk($sformatf("vec%0d irq_id", k), 32'(irq_id), 32'(tbl[k].id));
      chk($sformatf("vec%0d in_isr", k), 32'(in_isr), 32'(tbl[k].isr));
      chk($sformatf("vec%0d stack_empty", k), 32'(stack_empty), 32'(tbl[k].emp));
    end

    // Nesting: channel 0 preempts channel 2; channel 3 waits for both returns.
    do_reset();
    step(1, 3'd2, 0, 'h20, 0, 4'b0000);
    step(0, 3'd0, 0, 0, 0, 4'b1100);
    chk("nest pend id", 32'(irq_id), 2);
    step(1, 3'd4, 0, 0, 0, 4'b0000);
    chk("nest ch2 pc", 32'(pc), 18);
    chk("nest ch3 masked", 32'(irq_pending), 0);
    step(0, 3'd0, 0, 0, 0, 4'b0001);
    chk("nest ch0 pending", 32'(irq_pending), 1);
    chk("nest ch0 id", 32'(irq_id), 0);
    step(1, 3'd4, 0, 0, 0, 4'b0000);
    chk("nest ch0 pc", 32'(pc), 10);
    chk("nest ch0 masked after", 32'(irq_pending), 0);
    step(1, 3'd5, 0, 0, 0, 4'b0000);
    chk("nest ret1 pc", 32'(pc), 18);
    chk("nest ret1 ch3 masked", 32'(irq_pending), 0);
    chk("nest ret1 in_isr", 32'(in_isr), 1);
    step(1, 3'd5, 0, 0, 0, 4'b0000);
    chk("nest ret2 pc", 32'(pc), 'h20);
    chk("nest ret2 pending", 32'(irq_pending), 1);
    chk("nest ret2 id", 32'(irq_id), 3);
    chk("nest ret2 empty", 32'(stack_empty), 1);

    // Call chain to full, overflow, LIFO returns, then underflow.
    do_reset();
    ret_exp.delete();
    pc_before = 0;
    for (int k = 0; k < 9; k++) begin
      t[k] = 'h40 + 3 * k;
      if (k < DEPTH) ret_exp.push_back(pc_before + 1);
      step(1, 3'd2, 1, t[k], 0, 4'b0000);
      pc_before = t[k];
      if (k == DEPTH - 1) begin
        chk("call full", 32'(stack_full), 1);
        chk("call no ovf yet", 32'(stack_ovf), 0);
      end
    end
    chk("ovf flag", 32'(stack_ovf), 1);
    chk("ovf pc", 32'(pc), 32'(t[8]));
    chk("ovf still full", 32'(stack_full), 1);
    for (int k = 0; k < DEPTH; k++) begin
      step(1, 3'd5, 0, 0, 0, 4'b0000);
      chk($sformatf("ret%0d pc", k), 32'(pc), 32'(ret_exp.pop_back()));
    end
    chk("ret empty", 32'(stack_empty), 1);
    step(1, 3'd2, 0, 'h33, 0, 4'b0000);
    step(1, 3'd5, 0, 0, 0, 4'b0000);
    chk("unf flag", 32'(stack_unf), 1);
    chk("unf pc", 32'(pc), 0);
    chk("unf empty", 32'(stack_empty), 1);
    step(1, 3'd2, 0, 'h33, 0, 4'b0000);
    step(1, 3'd4, 0, 0, 0, 4'b0000);
    chk("vec no pend pc", 32'(pc), 'h33);
    chk("ovf sticky", 32'(stack_ovf), 1);

    // Reset between edges with three entries stacked and an ISR running.
    step(0, 3'd0, 0, 0, 0, 4'b0001);
    step(1, 3'd4, 0, 0, 0, 4'b0000);
    step(1, 3'd2, 1, 'h30, 0, 4'b0000);
    step(1, 3'd2, 1, 'h55, 0, 4'b0000);
    chk("pre-reset pc", 32'(pc), 'h55);
    chk("pre-reset in_isr", 32'(in_isr), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset pc", 32'(pc), 0);
    chk("midreset empty", 32'(stack_empty), 1);
    chk("midreset in_isr", 32'(in_isr), 0);
    chk("midreset ovf", 32'(stack_ovf), 0);
    chk("midreset unf", 32'(stack_unf), 0);
    #1 reset = 1'b0;
    model_reset();

    // Randomized run against the reference model.
    for (int n = 0; n < 1500; n++) begin
      bit ld;
      bit [3:0] rq;
      ld = ($urandom_range(0, 9) < 7);
      for (int b = 0; b < NUM_IRQ; b++) rq[b] = ($urandom_range(0, 5) == 0);
      step(ld, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), rq);
      check_model($sformatf("rnd%0d", n));
      if (n == 700) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
